// File: rtl/frame_buffer_pkg.sv
// ---------------------------------------------------------------------------
// frame_buffer_pkg: shared types for the frame-buffer scanout engine
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package frame_buffer_pkg;

    // Pixel width carried by the beat struct; the top-level DATA_SIZE must match.
    localparam int PIXEL_W = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2,
        FLIP   = 2'd3
    } scanout_state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic               line_end;
        logic               frame_end;
    } pixel_beat_t;

endpackage

`default_nettype wire

// File: rtl/scanout_skid_fifo.sv
// ---------------------------------------------------------------------------
// scanout_skid_fifo: 2-entry FIFO of pixel beats between SRAM return and output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scanout_skid_fifo
    import frame_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        push_i,
    input  pixel_beat_t push_beat_i,
    input  logic        pop_i,
    output pixel_beat_t head_o,
    output logic [1:0]  count_o
);

    pixel_beat_t mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        w_pop;

    // The issuing side never pushes into a full FIFO, so only pop needs guarding.
    assign w_pop = pop_i && (count_q != 2'd0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_beat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/frame_buffer_scanout.sv
// ---------------------------------------------------------------------------
// frame_buffer_scanout: raster read engine for the double-buffered pixel SRAM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_buffer_scanout
    import frame_buffer_pkg::*;
#(
    parameter int ADDR_SIZE    = 8,
    parameter int DATA_SIZE    = PIXEL_W,
    parameter int H_PIXELS     = 16,
    parameter int V_LINES      = 16,
    parameter int BLANK_CYCLES = 4
)(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 enable,
    input  logic                 frame_done,
    output logic [ADDR_SIZE-1:0] read_addr,
    input  logic [DATA_SIZE-1:0] read_data,
    output logic                 flip,
    output logic [DATA_SIZE-1:0] pixel_data,
    output logic                 pixel_valid,
    input  logic                 pixel_ready,
    output logic                 line_end,
    output logic                 frame_end,
    output logic                 flip_pending
);

    localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int BW = $clog2(BLANK_CYCLES);
    localparam logic [XW-1:0] X_LAST     = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_LINES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    scanout_state_t       state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [BW-1:0]        blank_q, blank_d;
    logic                 flip_pending_q, flip_pending_d;
    logic                 inflight_q;
    logic                 line_end_q;
    logic                 frame_end_q;

    logic                 w_issue;
    logic                 w_x_last;
    logic                 w_y_last;
    logic                 w_blank_done;
    logic                 w_credit;
    logic [1:0]           w_fifo_count;
    logic [1:0]           w_outstanding;
    pixel_beat_t          w_push_beat;
    pixel_beat_t          w_head;

    assign w_x_last      = (x_q == X_LAST);
    assign w_y_last      = (y_q == Y_LAST);
    assign w_blank_done  = (blank_q == BLANK_LAST);
    // Beats queued plus the one read still in the SRAM pipe must fit the 2-entry FIFO.
    assign w_outstanding = w_fifo_count + {1'b0, inflight_q};
    assign w_credit      = (w_outstanding < 2'd2);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        blank_d = blank_q;
        w_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ACTIVE;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ACTIVE: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    addr_d  = addr_q + ADDR_SIZE'(1);
                    if (w_x_last) begin
                        x_d = '0;
                        if (w_y_last) begin
                            y_d     = '0;
                            addr_d  = '0;
                            blank_d = '0;
                            state_d = BLANK;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            BLANK: begin
                if (!w_blank_done) begin
                    blank_d = blank_q + BW'(1);
                end else if (!inflight_q && (w_fifo_count == 2'd0)) begin
                    if (flip_pending_q) begin
                        state_d = FLIP;
                    end else if (enable) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLIP: begin
                state_d = enable ? ACTIVE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign flip = (state_q == FLIP);
    // A frame_done arriving with the flip re-arms the flag for the next blank.
    assign flip_pending_d = (flip_pending_q && !flip) || frame_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            x_q            <= '0;
            y_q            <= '0;
            blank_q        <= '0;
            flip_pending_q <= 1'b0;
            inflight_q     <= 1'b0;
            line_end_q     <= 1'b0;
            frame_end_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            x_q            <= x_d;
            y_q            <= y_d;
            blank_q        <= blank_d;
            flip_pending_q <= flip_pending_d;
            inflight_q     <= w_issue;
            line_end_q     <= w_issue && w_x_last;
            frame_end_q    <= w_issue && w_x_last && w_y_last;
        end
    end

    assign w_push_beat.data      = read_data;
    assign w_push_beat.line_end  = line_end_q;
    assign w_push_beat.frame_end = frame_end_q;

    scanout_skid_fifo u_fifo (
        .clk         (clk),
        .n_rst       (n_rst),
        .push_i      (inflight_q),
        .push_beat_i (w_push_beat),
        .pop_i       (pixel_ready),
        .head_o      (w_head),
        .count_o     (w_fifo_count)
    );

    assign read_addr    = addr_q;
    assign pixel_valid  = (w_fifo_count != 2'd0);
    assign pixel_data   = w_head.data;
    assign line_end     = w_head.line_end;
    assign frame_end    = w_head.frame_end;
    assign flip_pending = flip_pending_q;

endmodule

`default_nettype wire
